// File: rtl/pc_ctrl_if.sv
// Fetch-control bus between the pipeline front end and pc_ctrl.
// redirect_en/exc/stall are single-cycle qualifiers sampled on every rising edge; there is no ready/backpressure.
interface pc_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect_en;
    logic [WIDTH-1:0] redirect_addr;
    logic             call;
    logic             ret;
    logic             exc;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             fetch_valid;
    logic             misalign;
    logic             ras_empty;
    logic             ras_full;

    modport master (
        output stall, redirect_en, redirect_addr, call, ret, exc,
        input  pc, pc_plus, fetch_valid, misalign, ras_empty, ras_full
    );

    modport slave (
        input  stall, redirect_en, redirect_addr, call, ret, exc,
        output pc, pc_plus, fetch_valid, misalign, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter controller: next PC priority exc > redirect > stall > pc+STEP.
// Define PC_CTRL_RAS_EN to build the return-address stack used by call/ret redirects.
module pc_ctrl #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80),
    parameter int               RAS_DEPTH    = 4
) (
    input logic      clk,
    input logic      reset,
    pc_ctrl_if.slave bus
);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] stack_top;
    logic             fetch_valid_q;
    logic             misalign_q;
    logic             misalign_d;
    logic             take_redirect;
    logic             from_stack;

    assign pc_inc        = pc_q + WIDTH'(STEP);
    assign target        = bus.redirect_addr & ~LOW_MASK;
    assign take_redirect = bus.redirect_en & ~bus.exc;

`ifdef PC_CTRL_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_top;
    logic [PW:0]      ras_cnt;
    logic             do_call;
    logic             do_ret;
    logic             ras_is_empty;
    logic             ras_is_full;
    logic             push;
    logic             pop;
    logic             swap;

    assign ras_is_empty = (ras_cnt == '0);
    assign ras_is_full  = (ras_cnt == (PW + 1)'(RAS_DEPTH));
    assign do_call      = take_redirect & bus.call;
    assign do_ret       = take_redirect & bus.ret;
    assign from_stack   = do_ret & ~ras_is_empty;
    assign stack_top    = ras_mem[ras_top];
    // A call+ret with an empty stack degenerates into a plain push.
    assign push         = do_call & ~from_stack;
    assign pop          = from_stack & ~do_call;
    assign swap         = do_call & from_stack;

    // Circular buffer: a push when full advances over the oldest entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_top <= '0;
            ras_cnt <= '0;
        end else if (push) begin
            ras_top <= ras_top + PW'(1);
            if (!ras_is_full) ras_cnt <= ras_cnt + (PW + 1)'(1);
        end else if (pop) begin
            ras_top <= ras_top - PW'(1);
            ras_cnt <= ras_cnt - (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) ras_mem[ras_top + PW'(1)] <= pc_inc;
        else if (swap) ras_mem[ras_top] <= pc_inc;
    end

    assign bus.ras_empty = ras_is_empty;
    assign bus.ras_full  = ras_is_full;
`else
    logic [1:0] unused_ras_in;
    localparam int unused_ras_depth = RAS_DEPTH;

    assign unused_ras_in = {bus.call, bus.ret};
    assign from_stack    = 1'b0;
    assign stack_top     = '0;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (bus.exc) begin
            pc_d = EXC_VECTOR;
        end else if (bus.redirect_en) begin
            if (from_stack) begin
                pc_d = stack_top;
            end else begin
                pc_d       = target;
                misalign_d = |(bus.redirect_addr & LOW_MASK);
            end
        end else if (!bus.stall) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_VECTOR;
            misalign_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            misalign_q    <= misalign_d;
            fetch_valid_q <= 1'b1;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus     = pc_inc;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_valid = fetch_valid_q;
endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter WIDTH, 32, PC width in bits.
REQ-002 Parameter STEP, 4, sequential increment; power of two, at least 1.
REQ-003 Parameter RESET_VECTOR, 0, PC value loaded on reset.
REQ-004 Parameter EXC_VECTOR, 32'h80, PC value loaded on exception.
REQ-005 Parameter RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2.
REQ-006 Port clk  input  1  clock, rising-edge active.
REQ-007 Port reset  input  1  asynchronous active-low reset.
REQ-008 Port stall  input  1  hold PC this cycle.
REQ-009 Port redirect_en  input  1  branch/jump taken.
REQ-010 Port redirect_addr  input  WIDTH  branch/jump target.
REQ-011 Port call  input  1  redirect is a call (push).
REQ-012 Port ret  input  1  redirect is a return (pop).
REQ-013 Port exc  input  1  exception request.
REQ-014 Port pc  output  WIDTH  current fetch address, registered.
REQ-015 Port pc_plus  output  WIDTH  pc+STEP, combinational.
REQ-016 Port fetch_valid  output  1  pc is a valid fetch address.
REQ-017 Port misalign  output  1  previous cycle's accepted redirect target was misaligned, registered.
REQ-018 Port ras_empty  output  1  stack holds no entries.
REQ-019 Port ras_full  output  1  stack holds RAS_DEPTH entries.

Function
REQ-020 Next-PC priority SHALL be: exc, then redirect_en, then stall (hold), then pc+STEP.
REQ-021 exc SHALL load EXC_VECTOR next edge regardless of stall, redirect_en, call, ret; stack unchanged.
REQ-022 redirect_en without exc SHALL override stall; target is redirect_addr with low log2(STEP) bits forced to 0.
REQ-023 misalign SHALL be 1 for exactly one cycle after a redirect accepted with nonzero low log2(STEP) bits in redirect_addr, else 0; returns from the stack never set it.
REQ-024 Sequential increment SHALL wrap modulo 2^WIDTH (all-ones region + STEP -> low addresses, no flag).
REQ-025 call, ret SHALL be ignored unless redirect_en=1 and exc=0 in the same cycle.
REQ-026 call: push pc+STEP; PC <= redirect target; push when full overwrites oldest entry, count stays RAS_DEPTH.
REQ-027 ret, stack non-empty: PC <= top entry, pop; ret, stack empty: PC <= redirect target, no pop.
REQ-028 call and ret together: PC <= top entry (or redirect target if empty), top replaced by pc+STEP, count unchanged (or 1 if was empty).
REQ-029 fetch_valid SHALL be 0 in reset and 1 from the first rising edge after reset deasserts.
REQ-030 Latency SHALL be one cycle from qualifying input to new pc; no combinational path from inputs to pc.

Reset
REQ-031 reset=0 SHALL immediately force pc=RESET_VECTOR, fetch_valid=0, misalign=0, stack count 0 (ras_empty=1, ras_full=0), independent of clk.
REQ-032 Reset asserted mid-redirect or mid-stall SHALL discard that request; first post-reset edge increments from RESET_VECTOR unless other inputs active.

Configuration
REQ-033 Macro PC_CTRL_RAS_EN defined: stack per REQ-026..028 built in.
REQ-034 Macro PC_CTRL_RAS_EN undefined: no stack storage; call and ret ignored (redirect uses redirect_addr); ras_empty tied 1, ras_full tied 0.

Verification
REQ-035 Reset released, no inputs, WIDTH=32 STEP=4 -> pc 0,4,8,12 on successive edges; fetch_valid 1 after first edge.
REQ-036 pc=8, stall=1 two cycles, then redirect_en=1 redirect_addr=0x102 with stall=1 -> pc 8,8 then 0x100; misalign=1 one cycle.
REQ-037 Macro on: pc=0x10 call redirect 0x200; pc=0x200 ret redirect 0x999 -> pc 0x200 then 0x14; ras_empty 1 after ret.
REQ-038 Macro on, RAS_DEPTH=4: five calls from pc 0x0,0x100,0x200,0x300,0x400 then five rets -> returns 0x404,0x304,0x204,0x104, fifth uses redirect_addr; ras_full 1 after fourth call.
REQ-039 exc=1 with redirect_en=1 call=1 stall=1 -> pc 0x80, stack count unchanged; pc=0xFFFFFFFC increments to 0x0.
REQ-040 reset pulsed low mid-clock while redirect_en=1 -> pc=0 immediately, misalign 0, ras_empty 1, fetch_valid 0.
